// File: rtl/val_rd_pkg.sv
// Shared constants, state encoding and index-width helper for the Val read-channel arbiter.
package val_rd_pkg;

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Requester index width; a single requester still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/val_rd_order_fifo.sv
// Grant-order FIFO: records which requester owns each outstanding burst (read-first, no bypass).
module val_rd_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // storage write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/val_rd_arbiter.sv
// Round-robin sharing of the HBM Val read channel; R bursts return in grant order.
// Optional VAL_RD_PERF_EN adds per-requester R beat counters on perf_beats.
module val_rd_arbiter
    import val_rd_pkg::*;
#(
    parameter int CONF_NUM_KERNEL = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 256
) (
    input  logic                                 axis_clk,
    input  logic                                 axis_rst,
    input  logic [CONF_NUM_KERNEL*ADDR_WIDTH-1:0] s_araddr,
    input  logic [CONF_NUM_KERNEL*8-1:0]          s_arlen,
    input  logic [CONF_NUM_KERNEL-1:0]            s_arvalid,
    output logic [CONF_NUM_KERNEL-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  s_rlast,
    output logic [CONF_NUM_KERNEL-1:0]            s_rvalid,
    input  logic [CONF_NUM_KERNEL-1:0]            s_rready,
    output logic [ADDR_WIDTH-1:0]                 m_axi_araddr,
    output logic [7:0]                            m_axi_arlen,
    output logic [2:0]                            m_axi_arsize,
    output logic [1:0]                            m_axi_arburst,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0]                 m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready,
    output logic                                  busy,
    output logic                                  err_orphan_r
`ifdef VAL_RD_PERF_EN
    ,
    output logic [CONF_NUM_KERNEL*32-1:0]         perf_beats
`endif
);

    localparam int N     = CONF_NUM_KERNEL;
    localparam int IDX_W = idx_w(CONF_NUM_KERNEL);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDX_W-1:0]      grant_r;
    logic [IDX_W-1:0]      last_grant_r;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic [7:0]            arlen_r;
    logic                  arvalid_r;
    logic                  orphan_r;

    logic [IDX_W-1:0]      win_hi_s;
    logic [IDX_W-1:0]      win_lo_s;
    logic                  any_hi_s;
    logic [IDX_W-1:0]      win_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [7:0]            sel_len_s;
    logic                  arb_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_ready_s;
    logic [IDX_W-1:0]      head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
    always_comb begin
        win_hi_s = '0;
        win_lo_s = '0;
        any_hi_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            win_lo_s = s_arvalid[i] ? IDX_W'(i) : win_lo_s;
            win_hi_s = (s_arvalid[i] && (IDX_W'(i) > last_grant_r)) ? IDX_W'(i) : win_hi_s;
            any_hi_s = any_hi_s | (s_arvalid[i] && (IDX_W'(i) > last_grant_r));
        end
    end

    assign win_s  = any_hi_s ? win_hi_s : win_lo_s;
    assign arb_s  = (state_r == IDLE) && !fifo_full_s && (|s_arvalid);
    assign push_s = (state_r == ISSUE) && m_axi_arready;

    // winner payload select
    always_comb begin
        sel_addr_s = '0;
        sel_len_s  = '0;
        for (int i = 0; i < N; i++) begin
            sel_addr_s = (win_s == IDX_W'(i)) ? s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_len_s  = (win_s == IDX_W'(i)) ? s_arlen[i*8 +: 8] : sel_len_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = arb_s ? ISSUE : IDLE;
            ISSUE:   state_nxt_s = m_axi_arready ? IDLE : ISSUE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // state, grant bookkeeping and registered AR payload
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(N - 1);
            araddr_r     <= '0;
            arlen_r      <= '0;
            arvalid_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (arb_s) begin
                grant_r      <= win_s;
                last_grant_r <= win_s;
                araddr_r     <= sel_addr_s;
                arlen_r      <= sel_len_s;
                arvalid_r    <= 1'b1;
            end else if (push_s) begin
                arvalid_r <= 1'b0;
            end
        end
    end

    // R beat with no outstanding burst is a protocol fault; flag stays set until reset
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            orphan_r <= 1'b0;
        end else if (m_axi_rvalid && fifo_empty_s) begin
            orphan_r <= 1'b1;
        end
    end

    val_rd_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (axis_clk),
        .rst   (axis_rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (grant_r),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // steer R valid to the FIFO head and take its ready
    always_comb begin
        s_rvalid     = '0;
        s_arready    = '0;
        head_ready_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_rvalid[i]  = m_axi_rvalid & ~fifo_empty_s & (head_s == IDX_W'(i));
            s_arready[i] = push_s & (grant_r == IDX_W'(i));
            head_ready_s = head_ready_s | (s_rready[i] & (head_s == IDX_W'(i)));
        end
    end

    assign m_axi_rready  = ~fifo_empty_s & head_ready_s;
    assign pop_s         = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign s_rdata       = m_axi_rdata;
    assign s_rresp       = m_axi_rresp;
    assign s_rlast       = m_axi_rlast;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_arsize  = AXI_SIZE_32B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign busy          = (fifo_count_s != '0) | (state_r == ISSUE);
    assign err_orphan_r  = orphan_r;

`ifdef VAL_RD_PERF_EN
    logic [N*32-1:0] perf_r;

    // per-requester R handshake counters, free-running
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            perf_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s_rvalid[i] && s_rready[i]) begin
                    perf_r[i*32 +: 32] <= perf_r[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign perf_beats = perf_r;
`endif

endmodule

// File: tb/tb_val_rd_arbiter.sv
// Self-checking bench for val_rd_arbiter (N=4, MAX_OUTSTANDING=2) with AR/R scoreboards.
module tb_val_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 256;

    typedef struct {
        int          req;
        logic [47:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        int           req;
        logic [255:0] data;
        logic         last;
    } r_exp_t;

    typedef struct {
        logic [3:0] mask;
        int         exp_g;
    } vec_t;

    logic            clk = 1'b0;
    logic            axis_rst;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic            busy;
    logic            err_orphan_r;
`ifdef VAL_RD_PERF_EN
    logic [N*32-1:0] perf_beats;
`endif

    int      total = 0;
    int      bad = 0;
    int      issue_seq = 0;
    int      beats_seen [N];
    ar_exp_t ar_q [$];
    r_exp_t  r_q [$];
    vec_t    tbl [10];
    int      t2_seq [8];

    val_rd_arbiter #(
        .CONF_NUM_KERNEL (N),
        .MAX_OUTSTANDING (2),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .axis_clk      (clk),
        .axis_rst      (axis_rst),
        .s_araddr      (s_araddr),
        .s_arlen       (s_arlen),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .s_rdata       (s_rdata),
        .s_rresp       (s_rresp),
        .s_rlast       (s_rlast),
        .s_rvalid      (s_rvalid),
        .s_rready      (s_rready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .busy          (busy),
        .err_orphan_r  (err_orphan_r)
`ifdef VAL_RD_PERF_EN
        ,
        .perf_beats    (perf_beats)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] addr_of(input int r, input int seq);
        return 48'h0000_4000_0000 + 48'(r) * 48'h10_0000 + 48'(seq) * 48'h1000;
    endfunction

    // memory image returned by the HBM model for a given burst address and beat
    function automatic logic [255:0] image(input logic [47:0] a, input int b);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*32 +: 32] = (a[31:0] + 32'(b * 8 + j)) ^ 32'hA5A5_0000;
        end
        return w;
    endfunction

    task automatic prep(input int g, input int len, output logic [47:0] addr);
        ar_exp_t e;
        for (int r = 0; r < N; r++) begin
            s_araddr[r*AW +: AW] = addr_of(r, issue_seq);
        end
        s_arlen = {N{8'(len)}};
        addr = addr_of(g, issue_seq);
        issue_seq++;
        e.req = g;
        e.addr = addr;
        e.len = 8'(len);
        ar_q.push_back(e);
    endtask

    task automatic issue_mask(input logic [3:0] mask, input int g, input int len, output logic [47:0] addr);
        int lat;
        prep(g, len, addr);
        s_arvalid = mask;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (m_axi_arvalid) begin
                lat = k;
                break;
            end
        end
        chk("ar_latency", lat, 1);
        s_arvalid[g] = 1'b0;
        step();
    endtask

    task automatic drive_beat(input int req, input logic [47:0] addr, input int b, input int len);
        r_exp_t e;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = image(addr, b);
        m_axi_rresp = 2'b00;
        m_axi_rlast = (b == len);
        e.req = req;
        e.data = image(addr, b);
        e.last = (b == len);
        r_q.push_back(e);
    endtask

    task automatic serve(input int req, input logic [47:0] addr, input int len, input int stall_beat, input int stall_len);
        for (int b = 0; b <= len; b++) begin
            drive_beat(req, addr, b, len);
            if (b == stall_beat) begin
                s_rready[req] = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    #1;
                    chk("rready_stall", m_axi_rready, 1'b0);
                    step();
                end
                s_rready = 4'hF;
            end
            #1;
            chk("rready", m_axi_rready, 1'b1);
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
    endtask

    // AR scoreboard: compare every master handshake against the predicted grant
    always @(negedge clk) begin : ar_mon
        ar_exp_t e;
        if (m_axi_arvalid && m_axi_arready) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", 1'b1, 1'b0);
            end else begin
                e = ar_q.pop_front();
                chk("ar_addr", m_axi_araddr, e.addr);
                chk("ar_len", m_axi_arlen, e.len);
                chk("ar_ready_onehot", s_arready, 4'b0001 << e.req);
            end
        end
    end

    // R scoreboard: every routed handshake must match the next beat driven
    always @(negedge clk) begin : r_mon
        r_exp_t e;
        if (|(s_rvalid & s_rready)) begin
            if (r_q.size() == 0) begin
                chk("r_unexpected", 1'b1, 1'b0);
            end else begin
                e = r_q.pop_front();
                chk("r_route", s_rvalid, 4'b0001 << e.req);
                chk("r_data", s_rdata, e.data);
                chk("r_last", s_rlast, e.last);
                beats_seen[e.req]++;
            end
        end
    end

    initial begin
        logic [47:0] a0;
        logic [47:0] a1;
        logic [47:0] a2;

        tbl[0] = '{4'b0101, 0};
        tbl[1] = '{4'b0101, 2};
        tbl[2] = '{4'b1111, 3};
        tbl[3] = '{4'b1111, 0};
        tbl[4] = '{4'b0010, 1};
        tbl[5] = '{4'b1001, 3};
        tbl[6] = '{4'b1001, 0};
        tbl[7] = '{4'b0110, 1};
        tbl[8] = '{4'b0110, 2};
        tbl[9] = '{4'b1000, 3};
        t2_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int r = 0; r < N; r++) beats_seen[r] = 0;

        axis_rst = 1'b1;
        s_araddr = '0;
        s_arlen = '0;
        s_arvalid = '0;
        s_rready = 4'hF;
        m_axi_arready = 1'b1;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        step();
        step();
        axis_rst = 1'b0;
        #1;
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_araddr", m_axi_araddr, 48'h0);
        chk("rst_arlen", m_axi_arlen, 8'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_orphan_r, 1'b0);
        chk("rst_arready", s_arready, 4'h0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_rvalid", s_rvalid, 4'h0);
        chk("arsize", m_axi_arsize, 3'b101);
        chk("arburst", m_axi_arburst, 2'b01);

        // round-robin vectors, one single-beat burst each
        for (int i = 0; i < 10; i++) begin
            issue_mask(tbl[i].mask, tbl[i].exp_g, 0, a0);
            s_arvalid = '0;
            serve(tbl[i].exp_g, a0, 0, -1, 0);
            #1;
            chk("tbl_busy_idle", busy, 1'b0);
        end

        // all four requesting: strict rotation
        for (int k = 0; k < 8; k++) begin
            issue_mask(4'hF, t2_seq[k], 0, a0);
            s_arvalid = '0;
            serve(t2_seq[k], a0, 0, -1, 0);
        end

        // 0 and 2 together, 4-beat bursts, back-to-back AR; stall requester 2 mid-burst
        issue_mask(4'b0101, 0, 3, a0);
        issue_mask(4'b0100, 2, 3, a2);
        s_arvalid = '0;
        #1;
        chk("busy_outstanding", busy, 1'b1);
        serve(0, a0, 3, -1, 0);
        serve(2, a2, 3, 2, 5);
        #1;
        chk("busy_drop", busy, 1'b0);

        // full FIFO blocks arbitration until the first rlast pop
        issue_mask(4'b1000, 3, 0, a2);
        s_arvalid = '0;
        issue_mask(4'b0001, 0, 0, a0);
        s_arvalid = '0;
        prep(1, 0, a1);
        s_arvalid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("full_no_arvalid", m_axi_arvalid, 1'b0);
            chk("full_no_arready", s_arready, 4'h0);
        end
        serve(3, a2, 0, -1, 0);
        chk("no_ar_at_pop", m_axi_arvalid, 1'b0);
        step();
        chk("ar_after_pop", m_axi_arvalid, 1'b1);
        s_arvalid = '0;
        step();
        serve(0, a0, 0, -1, 0);
        serve(1, a1, 0, -1, 0);

        // orphan R beat with nothing outstanding
        m_axi_rvalid = 1'b1;
        m_axi_rlast = 1'b1;
        m_axi_rdata = {8{32'hDEAD_BEEF}};
        #1;
        chk("orphan_rready", m_axi_rready, 1'b0);
        chk("orphan_rvalid", s_rvalid, 4'h0);
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        chk("orphan_flag", err_orphan_r, 1'b1);
        step();
        step();
        step();
        chk("orphan_sticky", err_orphan_r, 1'b1);

`ifdef VAL_RD_PERF_EN
        for (int r = 0; r < N; r++) begin
            chk("perf_count", perf_beats[r*32 +: 32], 32'(beats_seen[r]));
        end
`endif

        // reset during beat 2 of an 8-beat burst
        issue_mask(4'b0100, 2, 7, a2);
        s_arvalid = '0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(2, a2, b, 7);
            #1;
            chk("rst_burst_rready", m_axi_rready, 1'b1);
            step();
        end
        drive_beat(2, a2, 2, 7);
        axis_rst = 1'b1;
        step();
        axis_rst = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_araddr", m_axi_araddr, 48'h0);
        chk("mid_rst_arlen", m_axi_arlen, 8'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rready", m_axi_rready, 1'b0);
        chk("mid_rst_rvalid", s_rvalid, 4'h0);
        chk("mid_rst_arready", s_arready, 4'h0);
        chk("mid_rst_err", err_orphan_r, 1'b0);
`ifdef VAL_RD_PERF_EN
        chk("mid_rst_perf", perf_beats, '0);
`endif
        step();
        step();
        chk("ar_queue_empty", ar_q.size(), 0);
        chk("r_queue_empty", r_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
